wb_pipe_chain: RTL
==================

Name: wb_pipe_chain

Overview:
Parametrised successor to the single-stage memory/writeback pipeline register. It is a DEPTH-stage elastic pipeline: each stage carries a payload, a destination register index and control bits, plus a per-stage valid bit. Stages move data on a valid/ready handshake, empty stages are filled automatically (bubble collapse), and a flush input squashes the whole chain. It sits between the memory stage and register-file writeback. It also exports per-stage destination indices to the hazard/forwarding unit.

Parameters:
DATA_W, 32, width of each of the two payload words (load data, ALU result)
RD_W, 5, destination register index width
CTRL_W, 2, control bit count (bit0 = regwrite, bit1 = memtoreg)
DEPTH, 2, number of register stages; legal range 1..4

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  synchronous, active-high; sampled on rising edge of clk
in_valid  in  1  upstream presents a valid entry
in_ready  out  1  chain can accept an entry this cycle
in_readdata  in  DATA_W  load data
in_alu_result  in  DATA_W  ALU result
in_rd  in  RD_W  destination register
in_ctrl  in  CTRL_W  control bits
flush  in  1  squash all in-flight entries
out_valid  out  1  last stage holds a valid entry
out_ready  in  1  writeback consumes the entry
out_readdata  out  DATA_W  last-stage load data
out_alu_result  out  DATA_W  last-stage ALU result
out_rd  out  RD_W  last-stage destination register
out_ctrl  out  CTRL_W  last-stage control bits, gated by out_valid
stage_valid  out  DEPTH  valid bit of each stage; bit 0 = input-side stage
stage_rd  out  DEPTH*RD_W  rd of stage i at bits [i*RD_W +: RD_W]; 0 when that stage is invalid
occupancy  out  clog2(DEPTH+1)  number of valid stages

Behaviour:
- Reset: all valid bits = 0. All payload, rd and ctrl registers = 0. Therefore out_valid = 0, out_* = 0, stage_valid = 0, stage_rd = 0, occupancy = 0, and in_ready = 1 combinationally.
- Reset takes priority over flush and over every handshake. Reset mid-stream discards all entries; no partial state survives.
- Stage readiness: ready[DEPTH-1] = ~valid[DEPTH-1] | out_ready. For i < DEPTH-1: ready[i] = ~valid[i] | ready[i+1]. in_ready = ready[0].
- The ready chain is a purely combinational path through all DEPTH stages. This is accepted because DEPTH ≤ 4.
- Stage load rules:
  - Stage i loads from stage i-1 (stage 0 loads from the inputs) when ready[i] = 1.
  - On load, valid[i] takes the upstream valid bit and the payload copies the upstream payload.
  - When ready[i] = 0, the stage holds.
  - Payload registers of an invalid stage may update freely and have no architectural meaning.
- Transfers: an input transfer happens on in_valid & in_ready. An output transfer happens on out_valid & out_ready.
- Latency and throughput: with out_ready held high, an accepted entry appears on out_* exactly DEPTH cycles later. Sustained throughput is 1 entry per cycle.
- Bubble collapse: a valid entry advances into an empty downstream stage even while out_ready = 0. The chain therefore buffers up to DEPTH entries.
- Full: all valid bits = 1 and out_ready = 0 gives in_ready = 0, and the chain holds all contents unchanged. Simultaneous full and out_ready = 1 lets the whole chain shift and accept one new entry in the same cycle.
- Flush:
  - At the next edge all valid bits are cleared.
  - An input transfer in the flush cycle is discarded.
  - An output transfer in the flush cycle completes normally; the consumer owns that entry.
  - flush with reset behaves as reset.
- Gating:
  - out_ctrl = last-stage ctrl & {CTRL_W{out_valid}}, so regwrite is never asserted for a bubble.
  - stage_rd slices are zeroed for invalid stages.
  - out_readdata, out_alu_result and out_rd are not gated.
- occupancy equals the popcount of the valid bits, computed combinationally.
- DEPTH = 1 degenerates to a single registered slot with the same handshake and flush rules.

Decomposition:
- Package wb_pipe_pkg holds:
  - default widths (DATA_W, RD_W, CTRL_W);
  - the ctrl bit indices CTRL_REGWRITE = 0 and CTRL_MEMTOREG = 1;
  - a packed struct for the payload {readdata, alu_result, rd, ctrl}.
- One sub-module, wb_pipe_slot, implements a single stage: valid register, payload register, ready computation and flush/reset handling. The top instantiates DEPTH slots in a generate loop and adds the output gating and occupancy.

Test Plan:
- Reset: assert reset for 2 cycles with in_valid = 1 → out_valid = 0, out_ctrl = 0, occupancy = 0, in_ready = 1; nothing is accepted.
- Streaming (DEPTH = 2): push rd = 1..8 back-to-back with out_ready = 1 → out_rd = 1..8 in order starting 2 cycles after the first push, one per cycle, with no gaps.
- Backpressure: out_ready = 0, push 3 entries → first 2 accepted and occupancy = 2, in_ready = 0 on the 3rd. Then raise out_ready → entries drain in order and the 3rd is accepted in the same cycle as the first pop.
- Flush: fill 2 entries with ctrl = 2'b01 and pulse flush while in_valid = 1 → next cycle occupancy = 0, out_ctrl = 0, stage_rd = 0, and the flush-cycle input never appears at the output.
- Bubble gating: push rd = 7, ctrl = 2'b11, then idle with in_valid = 0 → once rd 7 has been consumed, out_ctrl = 0 and stage_valid = 0; stage_rd is 7 only while the entry is resident in a stage.
- DEPTH = 1 and DEPTH = 4 builds: rerun the streaming test → latency is 1 and 4 cycles respectively; with out_ready = 0 the full condition is reached after 1 and 4 entries.

Source files
------------

// File: rtl/wb_pipe_pkg.sv
// Shared widths, control-bit indices and payload layout for the writeback pipeline chain.
package wb_pipe_pkg;

  localparam int DATA_W        = 32;
  localparam int RD_W          = 5;
  localparam int CTRL_W        = 2;
  localparam int CTRL_REGWRITE = 0;
  localparam int CTRL_MEMTOREG = 1;

  typedef struct packed {
    logic [DATA_W-1:0] readdata;
    logic [DATA_W-1:0] alu_result;
    logic [RD_W-1:0]   rd;
    logic [CTRL_W-1:0] ctrl;
  } wb_payload_t;

  // Chain depth never exceeds four, so a 4-bit population count covers every build.
  function automatic logic [2:0] popcount4(input logic [3:0] bits);
    logic [2:0] n;
    n = 3'd0;
    for (int i = 0; i < 4; i++) begin
      n = n + {2'b00, bits[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/wb_pipe_slot.sv
// One elastic stage: valid bit, payload register and the local link of the ready chain.
module wb_pipe_slot
  import wb_pipe_pkg::*;
#(
  parameter int W = $bits(wb_payload_t)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         up_valid,
  input  logic [W-1:0] up_data,
  input  logic         down_ready,
  output logic         ready,
  output logic         valid,
  output logic [W-1:0] data
);

  // An empty stage always accepts, which is what collapses bubbles.
  assign ready = ~valid | down_ready;

  // Stage state: reset clears everything, flush drops the valid bit, otherwise load on ready.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= 1'b0;
      data  <= {W{1'b0}};
    end else begin
      if (flush) begin
        valid <= 1'b0;
      end else if (ready) begin
        valid <= up_valid;
      end else begin
        valid <= valid;
      end
      if (ready) begin
        data <= up_data;
      end else begin
        data <= data;
      end
    end
  end

endmodule

// File: rtl/wb_pipe_chain.sv
// DEPTH-stage elastic memory/writeback pipeline with flush, bubble collapse and
// per-stage destination export for the hazard unit.
module wb_pipe_chain
  import wb_pipe_pkg::*;
#(
  parameter int DATA_W = wb_pipe_pkg::DATA_W,
  parameter int RD_W   = wb_pipe_pkg::RD_W,
  parameter int CTRL_W = wb_pipe_pkg::CTRL_W,
  parameter int DEPTH  = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [DATA_W-1:0]            in_readdata,
  input  logic [DATA_W-1:0]            in_alu_result,
  input  logic [RD_W-1:0]              in_rd,
  input  logic [CTRL_W-1:0]            in_ctrl,
  input  logic                         flush,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DATA_W-1:0]            out_readdata,
  output logic [DATA_W-1:0]            out_alu_result,
  output logic [RD_W-1:0]              out_rd,
  output logic [CTRL_W-1:0]            out_ctrl,
  output logic [DEPTH-1:0]             stage_valid,
  output logic [DEPTH*RD_W-1:0]        stage_rd,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

  localparam int PW    = 2*DATA_W + RD_W + CTRL_W;
  localparam int OCC_W = $clog2(DEPTH+1);

  // Flat payload layout, LSB first: ctrl, rd, alu_result, readdata.
  logic [PW-1:0] in_payload;
  logic [PW-1:0] last_payload;

  assign in_payload = {in_readdata, in_alu_result, in_rd, in_ctrl};

  genvar i;
  generate
    for (i = 0; i < DEPTH; i++) begin : g_stage
      logic          up_valid;
      logic          down_ready;
      logic          slot_ready;
      logic          slot_valid;
      logic [PW-1:0] up_data;
      logic [PW-1:0] slot_data;

      if (i == 0) begin : g_head
        assign up_valid = in_valid;
        assign up_data  = in_payload;
      end else begin : g_body
        assign up_valid = g_stage[i-1].slot_valid;
        assign up_data  = g_stage[i-1].slot_data;
      end

      if (i == DEPTH-1) begin : g_tail
        assign down_ready = out_ready;
      end else begin : g_mid
        assign down_ready = g_stage[i+1].slot_ready;
      end

      wb_pipe_slot #(.W(PW)) u_slot (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .up_valid   (up_valid),
        .up_data    (up_data),
        .down_ready (down_ready),
        .ready      (slot_ready),
        .valid      (slot_valid),
        .data       (slot_data)
      );

      assign stage_valid[i]              = slot_valid;
      assign stage_rd[i*RD_W +: RD_W]    = slot_valid ? slot_data[CTRL_W +: RD_W] : {RD_W{1'b0}};
    end
  endgenerate

  assign in_ready     = g_stage[0].slot_ready;
  assign out_valid    = g_stage[DEPTH-1].slot_valid;
  assign last_payload = g_stage[DEPTH-1].slot_data;

  // Bubbles must never carry regwrite/memtoreg into the register file.
  assign out_ctrl       = last_payload[CTRL_W-1:0] & {CTRL_W{out_valid}};
  assign out_rd         = last_payload[CTRL_W +: RD_W];
  assign out_alu_result = last_payload[CTRL_W+RD_W +: DATA_W];
  assign out_readdata   = last_payload[CTRL_W+RD_W+DATA_W +: DATA_W];

  // Occupancy is a plain popcount of the stage valid bits.
  always_comb begin
    occupancy = OCC_W'(popcount4(4'(stage_valid)));
  end

endmodule
